la_cmd_rx: RTL and testbench
============================

Name: la_cmd_rx

Overview:
- Host-to-FPGA command decoder for the logic analyser.
- Consumes the UDP receive byte stream from the Ethernet/UDP stack (udp_rec_data_valid / udp_rec_rdata / udp_rec_data_length) and parses framed commands.
- Drives the capture configuration (sample_clk_cfg, sample_num, triger_type, trigger_channel) and the sample_run start pulse into the capture core.
- Complements the existing capture-to-network upload path.

Parameters:
- INPUT_WIDTH, 6: number of probe channels; trigger_channel must be < INPUT_WIDTH.
- MAGIC, 8'hA5: first byte of every command frame.
- DEF_CLK_CFG, 4'hD: reset value of sample_clk_cfg.
- DEF_SAMPLE_NUM, 32'h0000_3FFF: reset value of sample_num.
- DEF_TRIG_TYPE, 2'b11: reset value of triger_type.
- DEF_TRIG_CH, 3'd0: reset value of trigger_channel.

Ports:
- clk  input  1  UDP-side clock.
- rst_n  input  1  asynchronous active-low reset.
- udp_rec_data_valid  input  1  payload byte strobe; one frame = one contiguous high run.
- udp_rec_rdata  input  8  payload byte.
- udp_rec_data_length  input  16  UDP payload length, stable while valid is high.
- capture_busy  input  1  capture/upload in progress.
- sample_clk_cfg  output  4  committed sample clock select.
- sample_num  output  32  committed sample count.
- triger_type  output  2  committed trigger type.
- trigger_channel  output  3  committed trigger channel.
- sample_run  output  1  one-cycle start pulse.
- cmd_ok  output  1  one-cycle pulse: frame accepted.
- cmd_err  output  1  one-cycle pulse: frame rejected.
- err_code  output  3  reason for the last rejection; held until the next cmd_err.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: configuration outputs take the DEF_* parameter values; sample_run, cmd_ok, cmd_err and err_code are 0.
- Frame format: byte0 = MAGIC; byte1 = opcode; payload; final byte = XOR of all preceding bytes.
- Opcode 0x01 CFG, 10 bytes total. Payload in order:
  - clk_cfg byte, bits [3:0] used.
  - sample_num as 4 bytes, MSB first.
  - trig_type byte, bits [1:0] used.
  - trig_ch byte, bits [2:0] used.
- Opcode 0x02 RUN, 3 bytes total.
- States:
  - IDLE: valid & byte==MAGIC -> OPC; valid & other -> DRAIN (err 1).
  - OPC: 0x01 -> PAYLOAD; 0x02 -> CHK; other -> DRAIN (err 2).
  - PAYLOAD: capture bytes into shadow registers, never into outputs; after the 7th byte -> CHK.
  - CHK: receives the checksum byte -> DONE.
  - DONE: any further valid byte -> DRAIN (err 3, length).
  - DRAIN: ignore bytes until end of frame.
- Running XOR and an 8-bit saturating byte counter are updated on every valid byte.
- Valid falling mid-frame (any state before DONE) -> err 3 (short frame).
- End of frame (EOF) is the first cycle E with valid=0 after a high run. Evaluation happens on the clock edge closing cycle E; results are visible in cycle E+1. Checks, in priority order:
  1. Earlier latched error code.
  2. udp_rec_data_length (sampled with byte0) != byte count -> err 3.
  3. XOR mismatch -> err 4.
  4. CFG with trig_ch >= INPUT_WIDTH, or sample_num == 0 -> err 5.
  5. RUN while capture_busy=1 -> err 6.
- On success:
  - CFG: commit all four shadow fields simultaneously.
  - RUN: sample_run=1 for exactly one cycle.
  - cmd_ok=1 for exactly one cycle.
- On failure: cmd_err=1 for one cycle, err_code updated, no output changes.
- Return to IDLE in E+1.
- A new frame may start in E+1 (back-to-back).
- A CFG received while capture_busy=1 still commits; the capture core samples the configuration only at run start.
- Reset mid-frame discards shadow state and restores the DEF_* values.

Optional Feature:
- Macro LA_CMD_CNT_EN.
- When defined: adds outputs ok_cnt[15:0] and err_cnt[15:0], which increment with cmd_ok and cmd_err respectively, wrap at 16'hFFFF -> 0, and reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset -> outputs 4'hD, 32'h3FFF, 2'b11, 3'd0; no pulses.
- CFG frame A5 01 05 00 00 10 00 01 03 XOR, length 10 -> cmd_ok in E+1; sample_clk_cfg=5, sample_num=32'h1000, triger_type=1, trigger_channel=3, all changing in the same cycle.
- RUN frame A5 02 A7, capture_busy=0 -> sample_run high exactly one cycle, in E+1. Same frame with capture_busy=1 -> cmd_err, err_code=6, no sample_run.
- CFG frame with corrupted checksum -> err_code=4, outputs unchanged. First byte 5A -> err_code=1. Opcode 0x09 -> err_code=2.
- CFG with trig_ch=6 (INPUT_WIDTH=6) -> err_code=5. RUN frame with an extra 4th byte -> err_code=3. Length field 9 with 10 bytes sent -> err_code=3.
- Back-to-back CFG then RUN, second frame starting in E+1 -> two cmd_ok pulses, config committed before sample_run. Reset asserted mid-CFG -> defaults restored, no pulse.

Source files
------------

// File: rtl/la_cmd_rx.sv
// rtl/la_cmd_rx.sv - UDP command frame decoder driving the logic analyser capture configuration
// Optional: define LA_CMD_CNT_EN to add ok_cnt/err_cnt accepted/rejected frame counters.
module la_cmd_rx #(
  parameter int          INPUT_WIDTH    = 6,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter logic [3:0]  DEF_CLK_CFG    = 4'hD,
  parameter logic [31:0] DEF_SAMPLE_NUM = 32'h0000_3FFF,
  parameter logic [1:0]  DEF_TRIG_TYPE  = 2'b11,
  parameter logic [2:0]  DEF_TRIG_CH    = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        udp_rec_data_valid,
  input  logic [7:0]  udp_rec_rdata,
  input  logic [15:0] udp_rec_data_length,
  input  logic        capture_busy,
  output logic [3:0]  sample_clk_cfg,
  output logic [31:0] sample_num,
  output logic [1:0]  triger_type,
  output logic [2:0]  trigger_channel,
  output logic        sample_run,
  output logic        cmd_ok,
  output logic        cmd_err,
  output logic [2:0]  err_code
`ifdef LA_CMD_CNT_EN
  ,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_PAYLOAD, S_CHK, S_DONE, S_DRAIN
  } state_t;

  localparam logic [7:0] OP_CFG = 8'h01;
  localparam logic [7:0] OP_RUN = 8'h02;

  state_t      state_q, state_d;
  logic        is_cfg_q, is_cfg_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  xr_q, xr_d;
  logic [15:0] len_q, len_d;
  logic [2:0]  err_lat_q, err_lat_d;
  logic [3:0]  sh_clk_q, sh_clk_d;
  logic [31:0] sh_num_q, sh_num_d;
  logic [1:0]  sh_type_q, sh_type_d;
  logic [2:0]  sh_ch_q, sh_ch_d;
  logic [3:0]  clk_cfg_q, clk_cfg_d;
  logic [31:0] num_q, num_d;
  logic [1:0]  ttype_q, ttype_d;
  logic [2:0]  tch_q, tch_d;
  logic        run_q, run_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic [2:0]  eval_code;
`ifdef LA_CMD_CNT_EN
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
`endif

  // Frame parser and end-of-frame evaluation; all outputs come from flops
  always_comb begin
    state_d   = state_q;
    is_cfg_d  = is_cfg_q;
    cnt_d     = cnt_q;
    xr_d      = xr_q;
    len_d     = len_q;
    err_lat_d = err_lat_q;
    sh_clk_d  = sh_clk_q;
    sh_num_d  = sh_num_q;
    sh_type_d = sh_type_q;
    sh_ch_d   = sh_ch_q;
    clk_cfg_d = clk_cfg_q;
    num_d     = num_q;
    ttype_d   = ttype_q;
    tch_d     = tch_q;
    run_d     = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    eval_code = 3'd0;

    if (udp_rec_data_valid) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      xr_d  = xr_q ^ udp_rec_rdata;
      case (state_q)
        S_IDLE: begin
          // Byte 0 restarts all per-frame bookkeeping
          cnt_d     = 8'd1;
          xr_d      = udp_rec_rdata;
          len_d     = udp_rec_data_length;
          is_cfg_d  = 1'b0;
          err_lat_d = 3'd0;
          if (udp_rec_rdata == MAGIC) begin
            state_d = S_OPC;
          end else begin
            state_d   = S_DRAIN;
            err_lat_d = 3'd1;
          end
        end
        S_OPC: begin
          if (udp_rec_rdata == OP_CFG) begin
            state_d  = S_PAYLOAD;
            is_cfg_d = 1'b1;
          end else if (udp_rec_rdata == OP_RUN) begin
            state_d = S_CHK;
          end else begin
            state_d   = S_DRAIN;
            err_lat_d = 3'd2;
          end
        end
        S_PAYLOAD: begin
          // cnt_q is the index of the byte being received (byte 2 = clk_cfg)
          case (cnt_q)
            8'd2: sh_clk_d = udp_rec_rdata[3:0];
            8'd3: sh_num_d[31:24] = udp_rec_rdata;
            8'd4: sh_num_d[23:16] = udp_rec_rdata;
            8'd5: sh_num_d[15:8] = udp_rec_rdata;
            8'd6: sh_num_d[7:0] = udp_rec_rdata;
            8'd7: sh_type_d = udp_rec_rdata[1:0];
            8'd8: begin
              sh_ch_d = udp_rec_rdata[2:0];
              state_d = S_CHK;
            end
            default: ;
          endcase
        end
        S_CHK:   state_d = S_DONE;
        S_DONE: begin
          state_d   = S_DRAIN;
          err_lat_d = 3'd3;
        end
        default: state_d = S_DRAIN;
      endcase
    end else if (state_q != S_IDLE) begin
      // End of frame: first idle cycle after a valid run
      state_d = S_IDLE;
      if (err_lat_q != 3'd0)
        eval_code = err_lat_q;
      else if (state_q != S_DONE)
        eval_code = 3'd3;
      else if (len_q != {8'd0, cnt_q})
        eval_code = 3'd3;
      else if (xr_q != 8'd0)
        eval_code = 3'd4;
      else if (is_cfg_q && ((32'(sh_ch_q) >= 32'(INPUT_WIDTH)) || (sh_num_q == 32'd0)))
        eval_code = 3'd5;
      else if (!is_cfg_q && capture_busy)
        eval_code = 3'd6;
      else
        eval_code = 3'd0;

      if (eval_code == 3'd0) begin
        ok_d = 1'b1;
        if (is_cfg_q) begin
          clk_cfg_d = sh_clk_q;
          num_d     = sh_num_q;
          ttype_d   = sh_type_q;
          tch_d     = sh_ch_q;
        end else begin
          run_d = 1'b1;
        end
      end else begin
        err_d  = 1'b1;
        code_d = eval_code;
      end
    end
  end

`ifdef LA_CMD_CNT_EN
  // Frame statistics counters, wrapping naturally at 16 bits
  always_comb begin
    ok_cnt_d  = ok_d  ? ok_cnt_q + 16'd1  : ok_cnt_q;
    err_cnt_d = err_d ? err_cnt_q + 16'd1 : err_cnt_q;
  end
`endif

  // State register; reset drops any partial frame and restores defaults
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      is_cfg_q  <= 1'b0;
      cnt_q     <= 8'd0;
      xr_q      <= 8'd0;
      len_q     <= 16'd0;
      err_lat_q <= 3'd0;
      sh_clk_q  <= DEF_CLK_CFG;
      sh_num_q  <= DEF_SAMPLE_NUM;
      sh_type_q <= DEF_TRIG_TYPE;
      sh_ch_q   <= DEF_TRIG_CH;
      clk_cfg_q <= DEF_CLK_CFG;
      num_q     <= DEF_SAMPLE_NUM;
      ttype_q   <= DEF_TRIG_TYPE;
      tch_q     <= DEF_TRIG_CH;
      run_q     <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 3'd0;
`ifdef LA_CMD_CNT_EN
      ok_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      is_cfg_q  <= is_cfg_d;
      cnt_q     <= cnt_d;
      xr_q      <= xr_d;
      len_q     <= len_d;
      err_lat_q <= err_lat_d;
      sh_clk_q  <= sh_clk_d;
      sh_num_q  <= sh_num_d;
      sh_type_q <= sh_type_d;
      sh_ch_q   <= sh_ch_d;
      clk_cfg_q <= clk_cfg_d;
      num_q     <= num_d;
      ttype_q   <= ttype_d;
      tch_q     <= tch_d;
      run_q     <= run_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      code_q    <= code_d;
`ifdef LA_CMD_CNT_EN
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign sample_clk_cfg  = clk_cfg_q;
  assign sample_num      = num_q;
  assign triger_type     = ttype_q;
  assign trigger_channel = tch_q;
  assign sample_run      = run_q;
  assign cmd_ok          = ok_q;
  assign cmd_err         = err_q;
  assign err_code        = code_q;
`ifdef LA_CMD_CNT_EN
  assign ok_cnt  = ok_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_la_cmd_rx.sv
// tb/tb_la_cmd_rx.sv - table-driven self-checking bench for la_cmd_rx
module tb_la_cmd_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [7:0]  rdata;
  logic [15:0] length;
  logic        busy;
  logic [3:0]  sample_clk_cfg;
  logic [31:0] sample_num;
  logic [1:0]  triger_type;
  logic [2:0]  trigger_channel;
  logic        sample_run;
  logic        cmd_ok;
  logic        cmd_err;
  logic [2:0]  err_code;
`ifdef LA_CMD_CNT_EN
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  la_cmd_rx dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .udp_rec_data_valid  (valid),
    .udp_rec_rdata       (rdata),
    .udp_rec_data_length (length),
    .capture_busy        (busy),
    .sample_clk_cfg      (sample_clk_cfg),
    .sample_num          (sample_num),
    .triger_type         (triger_type),
    .trigger_channel     (trigger_channel),
    .sample_run          (sample_run),
    .cmd_ok              (cmd_ok),
    .cmd_err             (cmd_err),
    .err_code            (err_code)
`ifdef LA_CMD_CNT_EN
    ,
    .ok_cnt              (ok_cnt),
    .err_cnt             (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [40:0] CFG_DEF = {4'hD, 32'h0000_3FFF, 2'b11, 3'd0};
  localparam logic [40:0] CFG_A   = {4'h5, 32'h0000_1000, 2'b01, 3'd3};
  localparam logic [40:0] CFG_B   = {4'h2, 32'h1234_5678, 2'b10, 3'd5};

  typedef struct {
    logic [95:0] bytes;   // right-aligned, first byte most significant
    int          n;
    logic [15:0] len;
    logic        busy;
    logic        ok;
    logic        run;
    logic [2:0]  code;
    logic [40:0] cfg;
  } vec_t;

  vec_t vt [12];
  logic [40:0] prev_cfg;

  function automatic logic [40:0] cur_cfg();
    return {sample_clk_cfg, sample_num, triger_type, trigger_channel};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic [15:0] len);
    @(posedge clk); #1;
    valid  = 1'b1;
    rdata  = b;
    length = len;
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    valid = 1'b0;
    rdata = 8'h00;
  endtask

  task automatic send_frame(input logic [95:0] bytes, input int n, input logic [15:0] len);
    for (int i = 0; i < n; i++) drive_byte(bytes[8*(n-1-i) +: 8], len);
    end_frame();
  endtask

  initial begin
    rst_n  = 1'b0;
    valid  = 1'b0;
    rdata  = 8'h00;
    length = 16'd0;
    busy   = 1'b0;

    vt[0]  = '{96'hA5_01_05_00_00_10_00_01_03_B3, 10, 16'd10, 1'b0, 1'b1, 1'b0, 3'd0, CFG_A};
    vt[1]  = '{96'hA5_02_A7,                       3, 16'd3,  1'b0, 1'b1, 1'b1, 3'd0, CFG_A};
    vt[2]  = '{96'hA5_02_A7,                       3, 16'd3,  1'b1, 1'b0, 1'b0, 3'd6, CFG_A};
    vt[3]  = '{96'hA5_01_05_00_00_10_00_01_03_B4, 10, 16'd10, 1'b0, 1'b0, 1'b0, 3'd4, CFG_A};
    vt[4]  = '{96'h5A_02_58,                       3, 16'd3,  1'b0, 1'b0, 1'b0, 3'd1, CFG_A};
    vt[5]  = '{96'hA5_09_AC,                       3, 16'd3,  1'b0, 1'b0, 1'b0, 3'd2, CFG_A};
    vt[6]  = '{96'hA5_01_05_00_00_10_00_01_06_B6, 10, 16'd10, 1'b0, 1'b0, 1'b0, 3'd5, CFG_A};
    vt[7]  = '{96'hA5_01_05_00_00_00_00_01_03_A3, 10, 16'd10, 1'b0, 1'b0, 1'b0, 3'd5, CFG_A};
    vt[8]  = '{96'hA5_02_A7_00,                    4, 16'd4,  1'b0, 1'b0, 1'b0, 3'd3, CFG_A};
    vt[9]  = '{96'hA5_01_05_00_00_10_00_01_03_B3, 10, 16'd9,  1'b0, 1'b0, 1'b0, 3'd3, CFG_A};
    vt[10] = '{96'hA5_01_05,                       3, 16'd3,  1'b0, 1'b0, 1'b0, 3'd3, CFG_A};
    vt[11] = '{96'hA5_01_02_12_34_56_78_02_05_A9, 10, 16'd10, 1'b0, 1'b1, 1'b0, 3'd3, CFG_B};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cfg", 64'(cur_cfg()), 64'(CFG_DEF));
    chk("reset_pulses", 64'({sample_run, cmd_ok, cmd_err}), 64'd0);
    chk("reset_err_code", 64'(err_code), 64'd0);
    rst_n = 1'b1;
    prev_cfg = CFG_DEF;

    // Table-driven frames
    for (int v = 0; v < 12; v++) begin
      busy = vt[v].busy;
      send_frame(vt[v].bytes, vt[v].n, vt[v].len);
      // cycle E: nothing visible yet
      chk($sformatf("v%0d_E_pulses", v), 64'({sample_run, cmd_ok, cmd_err}), 64'd0);
      chk($sformatf("v%0d_E_cfg", v), 64'(cur_cfg()), 64'(prev_cfg));
      @(posedge clk); #1;
      // cycle E+1: result
      chk($sformatf("v%0d_ok", v), 64'(cmd_ok), 64'(vt[v].ok));
      chk($sformatf("v%0d_err", v), 64'(cmd_err), 64'(!vt[v].ok));
      chk($sformatf("v%0d_run", v), 64'(sample_run), 64'(vt[v].run));
      chk($sformatf("v%0d_code", v), 64'(err_code), 64'(vt[v].code));
      chk($sformatf("v%0d_cfg", v), 64'(cur_cfg()), 64'(vt[v].cfg));
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse_end", v), 64'({sample_run, cmd_ok, cmd_err}), 64'd0);
      prev_cfg = vt[v].cfg;
      busy = 1'b0;
    end

`ifdef LA_CMD_CNT_EN
    chk("ok_cnt", 64'(ok_cnt), 64'd3);
    chk("err_cnt", 64'(err_cnt), 64'd9);
`endif

    // Back-to-back CFG A then RUN starting in E+1
    send_frame(96'hA5_01_05_00_00_10_00_01_03_B3, 10, 16'd10);
    @(posedge clk); #1;
    chk("b2b_cfg_ok", 64'({cmd_ok, cmd_err, sample_run}), 64'b100);
    chk("b2b_cfg_commit", 64'(cur_cfg()), 64'(CFG_A));
    valid = 1'b1; rdata = 8'hA5; length = 16'd3;
    drive_byte(8'h02, 16'd3);
    drive_byte(8'hA7, 16'd3);
    end_frame();
    @(posedge clk); #1;
    chk("b2b_run_ok", 64'({cmd_ok, cmd_err, sample_run}), 64'b101);
    @(posedge clk); #1;
    chk("b2b_run_end", 64'({cmd_ok, cmd_err, sample_run}), 64'd0);

    // Reset asserted in the middle of a CFG frame
    drive_byte(8'hA5, 16'd10);
    drive_byte(8'h01, 16'd10);
    drive_byte(8'h02, 16'd10);
    drive_byte(8'h12, 16'd10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    chk("midrst_cfg", 64'(cur_cfg()), 64'(CFG_DEF));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst_quiet%0d", c), 64'({sample_run, cmd_ok, cmd_err, err_code}), 64'd0);
    end
    chk("midrst_cfg_hold", 64'(cur_cfg()), 64'(CFG_DEF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
